// File: rtl/lc3_pkg.sv
// Shared LC-3 control types: FSM states, opcodes, datapath select encodings
// and the bundle of control outputs decoded from the current state.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_F_MAR, S_F_RD, S_F_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP,
    S_JSR_R7, S_JSR_PC,
    S_LDR_MAR, S_LDR_RD, S_LDR_WB,
    S_STR_MAR, S_STR_MDR, S_STR_WR,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] SR1_IR11_9 = 2'b00;
  localparam logic [1:0] SR1_IR8_6  = 2'b01;
  localparam logic [1:0] DR_IR11_9  = 2'b00;
  localparam logic [1:0] DR_R7      = 2'b01;

  typedef struct packed {
    logic       gate_marmux;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_pc;
    logic       ld_reg;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_ir;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_pc;
    logic       ld_led;
    logic       addr1mux;
    logic       sr2mux;
    logic       mio_en;
    logic [1:0] pcmux;
    logic [1:0] drmux;
    logic [1:0] addr2mux;
    logic [1:0] sr1mux;
    logic [1:0] aluk;
    logic       mem_oe_n;
    logic       mem_we_n;
    logic       halted;
  } ctrl_t;

  // Everything inactive: loads/gates/selects low, memory strobes high.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c          = '0;
    c.mem_oe_n = 1'b1;
    c.mem_we_n = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/nzp_ben_unit.sv
// Condition codes and branch-enable flag. NZP follows the bus value captured
// whenever LD_CC is high; BEN samples the IR condition mask against NZP.
module nzp_ben_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_cc,
  input  logic        ld_ben,
  input  logic [15:0] bus,
  input  logic [2:0]  ir_cond,
  output logic        ben
);

  logic [2:0] nzp;

  // Capture NZP on LD_CC and BEN on LD_BEN; reset leaves Z set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp <= 3'b010;
      ben <= 1'b0;
    end else begin
      if (ld_cc) begin
        if (bus[15])         nzp <= 3'b100;
        else if (bus == '0)  nzp <= 3'b010;
        else                 nzp <= 3'b001;
      end
      if (ld_ben) ben <= |(ir_cond & nzp);
    end
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 subset control unit: Moore FSM sequencing fetch, decode and execute.
// Memory states are held for MEM_WAIT cycles by a down-counter; the same
// counter marks the first PAUSE1 cycle so LD_LED pulses exactly once.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic [15:0] Bus,
  output logic        GateMARMUX,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GatePC,
  output logic        LD_REG,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_IR,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        ADDR1MUX,
  output logic        SR2MUX,
  output logic        MIO_EN,
  output logic [1:0]  PCMUX,
  output logic [1:0]  DRMUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  SR1MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_OE_n,
  output logic        Mem_WE_n,
  output logic        Halted
);

  localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       ben;
  ctrl_t      c;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign unused_ir = ^{IR[8:6], IR[4:0]};

  // State and hold-counter sequencing.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_HALTED;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_HALTED:  if (Run) state <= S_F_MAR;
        S_F_MAR: begin
          state <= S_F_RD;
          cnt   <= WAIT_LD;
        end
        S_F_RD:    if (cnt == '0) state <= S_F_IR; else cnt <= cnt - 3'd1;
        S_F_IR:    state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_ADD:   state <= S_ADD;
            OP_AND:   state <= S_AND;
            OP_NOT:   state <= S_NOT;
            OP_BR:    state <= S_BR;
            OP_JMP:   state <= S_JMP;
            OP_JSR:   state <= S_JSR_R7;
            OP_LDR:   state <= S_LDR_MAR;
            OP_STR:   state <= S_STR_MAR;
            OP_PAUSE: begin
              state <= S_PAUSE1;
              cnt   <= 3'd1;
            end
            default:  state <= S_F_MAR;
          endcase
        end
        S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR_PC, S_LDR_WB:
          state <= S_F_MAR;
        S_BR:      state <= ben ? S_BR_TAKE : S_F_MAR;
        S_JSR_R7:  state <= S_JSR_PC;
        S_LDR_MAR: begin
          state <= S_LDR_RD;
          cnt   <= WAIT_LD;
        end
        S_LDR_RD:  if (cnt == '0) state <= S_LDR_WB; else cnt <= cnt - 3'd1;
        S_STR_MAR: state <= S_STR_MDR;
        S_STR_MDR: begin
          state <= S_STR_WR;
          cnt   <= WAIT_LD;
        end
        S_STR_WR:  if (cnt == '0) state <= S_F_MAR; else cnt <= cnt - 3'd1;
        S_PAUSE1: begin
          cnt <= '0;
          if (Continue) state <= S_PAUSE2;
        end
        S_PAUSE2:  if (!Continue) state <= S_F_MAR;
        default:   state <= S_HALTED;
      endcase
    end
  end

  // Control outputs decoded from the current state only (plus IR[5]).
  always_comb begin
    c        = ctrl_idle();
    c.sr2mux = IR[5];
    unique case (state)
      S_HALTED: begin
        c.halted = 1'b1;
        c.sr2mux = 1'b0;
      end
      S_F_MAR: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.pcmux   = PCMUX_INC;
        c.ld_pc   = 1'b1;
      end
      S_F_RD, S_LDR_RD: begin
        c.mio_en   = 1'b1;
        c.ld_mdr   = 1'b1;
        c.mem_oe_n = 1'b0;
      end
      S_F_IR: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S_DECODE: c.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        c.sr1mux   = SR1_IR8_6;
        c.drmux    = DR_IR11_9;
        c.aluk     = (state == S_ADD) ? ALUK_ADD :
                     (state == S_AND) ? ALUK_AND : ALUK_NOT;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_BR_TAKE: begin
        c.addr1mux = 1'b0;
        c.addr2mux = ADDR2_OFF9;
        c.pcmux    = PCMUX_ADDER;
        c.ld_pc    = 1'b1;
      end
      S_JMP: begin
        c.sr1mux   = SR1_IR8_6;
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.pcmux    = PCMUX_BUS;
        c.ld_pc    = 1'b1;
      end
      S_JSR_R7: begin
        c.gate_pc = 1'b1;
        c.drmux   = DR_R7;
        c.ld_reg  = 1'b1;
      end
      S_JSR_PC: begin
        c.addr1mux = 1'b0;
        c.addr2mux = ADDR2_OFF11;
        c.pcmux    = PCMUX_ADDER;
        c.ld_pc    = 1'b1;
      end
      S_LDR_MAR, S_STR_MAR: begin
        c.sr1mux      = SR1_IR8_6;
        c.addr1mux    = 1'b1;
        c.addr2mux    = ADDR2_OFF6;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      S_LDR_WB: begin
        c.gate_mdr = 1'b1;
        c.drmux    = DR_IR11_9;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_STR_MDR: begin
        c.sr1mux   = SR1_IR11_9;
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.mio_en   = 1'b0;
        c.ld_mdr   = 1'b1;
      end
      S_STR_WR:  c.mem_we_n = 1'b0;
      S_PAUSE1:  c.ld_led = (cnt != '0);
      default: ;
    endcase
  end

  nzp_ben_unit u_nzp_ben (
    .clk     (Clk),
    .rst_n   (Reset),
    .ld_cc   (c.ld_cc),
    .ld_ben  (c.ld_ben),
    .bus     (Bus),
    .ir_cond (IR[11:9]),
    .ben     (ben)
  );

  assign GateMARMUX = c.gate_marmux;
  assign GateMDR    = c.gate_mdr;
  assign GateALU    = c.gate_alu;
  assign GatePC     = c.gate_pc;
  assign LD_REG     = c.ld_reg;
  assign LD_BEN     = c.ld_ben;
  assign LD_CC      = c.ld_cc;
  assign LD_IR      = c.ld_ir;
  assign LD_MAR     = c.ld_mar;
  assign LD_MDR     = c.ld_mdr;
  assign LD_PC      = c.ld_pc;
  assign LD_LED     = c.ld_led;
  assign ADDR1MUX   = c.addr1mux;
  assign SR2MUX     = c.sr2mux;
  assign MIO_EN     = c.mio_en;
  assign PCMUX      = c.pcmux;
  assign DRMUX      = c.drmux;
  assign ADDR2MUX   = c.addr2mux;
  assign SR1MUX     = c.sr1mux;
  assign ALUK       = c.aluk;
  assign Mem_OE_n   = c.mem_oe_n;
  assign Mem_WE_n   = c.mem_we_n;
  assign Halted     = c.halted;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: three instances (MEM_WAIT 2, 1, 7). A model
// expands each instruction into its expected per-cycle control vectors.
module tb_lc3_control_fsm;

  typedef struct packed {
    logic       gmm, gmdr, galu, gpc;
    logic       ld_reg, ld_ben, ld_cc, ld_ir, ld_mar, ld_mdr, ld_pc, ld_led;
    logic       a1, sr2, mio;
    logic [1:0] pcm, drm, a2m, sr1, aluk;
    logic       oe_n, we_n, halted;
  } ob_t;

  typedef struct {
    ob_t         o;
    logic        run;
    logic        cont;
    logic [15:0] ir;
    logic [15:0] bus;
  } ent_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [3];
  logic        run_i  [3];
  logic        cont_i [3];
  logic [15:0] ir_i   [3];
  logic [15:0] bus_i  [3];
  ob_t         obv    [3];

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  int   sign;   // condition model: -1 negative, 0 zero, +1 positive

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic gmm, gmdr, galu, gpc, ld_reg, ld_ben, ld_cc, ld_ir, ld_mar, ld_mdr;
    logic ld_pc, ld_led, a1, sr2, mio, oe_n, we_n, halted;
    logic [1:0] pcm, drm, a2m, sr1, aluk;
    lc3_control_fsm #(.MEM_WAIT(g == 0 ? 2 : (g == 1 ? 1 : 7))) dut (
      .Clk(clk), .Reset(rst_n[g]), .Run(run_i[g]), .Continue(cont_i[g]),
      .IR(ir_i[g]), .Bus(bus_i[g]),
      .GateMARMUX(gmm), .GateMDR(gmdr), .GateALU(galu), .GatePC(gpc),
      .LD_REG(ld_reg), .LD_BEN(ld_ben), .LD_CC(ld_cc), .LD_IR(ld_ir),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_PC(ld_pc), .LD_LED(ld_led),
      .ADDR1MUX(a1), .SR2MUX(sr2), .MIO_EN(mio),
      .PCMUX(pcm), .DRMUX(drm), .ADDR2MUX(a2m), .SR1MUX(sr1), .ALUK(aluk),
      .Mem_OE_n(oe_n), .Mem_WE_n(we_n), .Halted(halted)
    );
    assign obv[g] = {gmm, gmdr, galu, gpc, ld_reg, ld_ben, ld_cc, ld_ir,
                     ld_mar, ld_mdr, ld_pc, ld_led, a1, sr2, mio,
                     pcm, drm, a2m, sr1, aluk, oe_n, we_n, halted};
  end

  function automatic int mw(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
  endfunction

  function automatic logic [15:0] rb();
    return 16'($urandom);
  endfunction

  function automatic ob_t base(input logic [15:0] ir);
    ob_t o;
    o      = '0;
    o.oe_n = 1'b1;
    o.we_n = 1'b1;
    o.sr2  = ir[5];
    return o;
  endfunction

  function automatic ob_t halted_vec();
    ob_t o;
    o        = '0;
    o.oe_n   = 1'b1;
    o.we_n   = 1'b1;
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic push(input ob_t o, input logic run, input logic cont,
                      input logic [15:0] ir, input logic [15:0] bus);
    ent_t e;
    e.o = o; e.run = run; e.cont = cont; e.ir = ir; e.bus = bus;
    q.push_back(e);
  endtask

  task automatic push_fmar(input logic [15:0] ir);
    ob_t o;
    o = base(ir); o.gpc = 1; o.ld_mar = 1; o.ld_pc = 1;
    push(o, 0, 0, ir, rb());
  endtask

  // Expected cycles of one instruction, from its fetch up to (not including)
  // the next fetch. ccb is the bus value shown while condition codes load.
  task automatic build(input int k, input logic [15:0] ir, input logic [15:0] ccb,
                       input int p1, input int p2);
    ob_t  o;
    logic ben;
    ben = (ir[11] && sign < 0) || (ir[10] && sign == 0) || (ir[9] && sign > 0);
    push_fmar(ir);
    for (int i = 0; i < mw(k); i++) begin
      o = base(ir); o.mio = 1; o.ld_mdr = 1; o.oe_n = 0; push(o, 0, 0, ir, rb());
    end
    o = base(ir); o.gmdr = 1; o.ld_ir = 1; push(o, 0, 0, ir, rb());
    o = base(ir); o.ld_ben = 1;            push(o, 0, 0, ir, rb());
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: begin
        o = base(ir); o.sr1 = 2'b01; o.galu = 1; o.ld_reg = 1; o.ld_cc = 1;
        o.aluk = (ir[15:12] == 4'h1) ? 2'b00 : (ir[15:12] == 4'h5) ? 2'b01 : 2'b10;
        push(o, 0, 0, ir, ccb);
        sign = ccb[15] ? -1 : ((ccb == 16'h0) ? 0 : 1);
      end
      4'h0: begin
        push(base(ir), 0, 0, ir, rb());
        if (ben) begin
          o = base(ir); o.a2m = 2'b10; o.pcm = 2'b10; o.ld_pc = 1;
          push(o, 0, 0, ir, rb());
        end
      end
      4'hC: begin
        o = base(ir); o.sr1 = 2'b01; o.aluk = 2'b11; o.galu = 1;
        o.pcm = 2'b01; o.ld_pc = 1; push(o, 0, 0, ir, rb());
      end
      4'h4: begin
        o = base(ir); o.gpc = 1; o.drm = 2'b01; o.ld_reg = 1; push(o, 0, 0, ir, rb());
        o = base(ir); o.a2m = 2'b11; o.pcm = 2'b10; o.ld_pc = 1; push(o, 0, 0, ir, rb());
      end
      4'h6, 4'h7: begin
        o = base(ir); o.sr1 = 2'b01; o.a1 = 1; o.a2m = 2'b01; o.gmm = 1; o.ld_mar = 1;
        push(o, 0, 0, ir, rb());
        if (ir[15:12] == 4'h6) begin
          for (int i = 0; i < mw(k); i++) begin
            o = base(ir); o.mio = 1; o.ld_mdr = 1; o.oe_n = 0; push(o, 0, 0, ir, rb());
          end
          o = base(ir); o.gmdr = 1; o.ld_reg = 1; o.ld_cc = 1; push(o, 0, 0, ir, ccb);
          sign = ccb[15] ? -1 : ((ccb == 16'h0) ? 0 : 1);
        end else begin
          o = base(ir); o.aluk = 2'b11; o.galu = 1; o.ld_mdr = 1; push(o, 0, 0, ir, rb());
          for (int i = 0; i < mw(k); i++) begin
            o = base(ir); o.we_n = 0; push(o, 0, 0, ir, rb());
          end
        end
      end
      4'hD: begin
        for (int i = 0; i <= p1; i++) begin
          o = base(ir); o.ld_led = (i == 0); push(o, 0, (i == p1), ir, rb());
        end
        for (int i = 0; i <= p2; i++) push(base(ir), 0, (i != p2), ir, rb());
      end
      default: ;
    endcase
  endtask

  // Play the queued cycles on instance k, comparing between edges.
  task automatic run_q(input int k, input string name, input int limit);
    int n;
    n = (limit < 0 || limit > q.size()) ? q.size() : limit;
    for (int i = 0; i < n; i++) begin
      run_i[k] = q[i].run; cont_i[k] = q[i].cont;
      ir_i[k]  = q[i].ir;  bus_i[k]  = q[i].bus;
      @(negedge clk);
      checks++;
      if (obv[k] !== q[i].o) begin
        errors++;
        $display("FAIL %s k%0d step %0d got %h exp %h", name, k, i, obv[k], q[i].o);
      end
      @(posedge clk); #1;
    end
    q.delete();
    run_i[k] = 0; cont_i[k] = 0;
  endtask

  task automatic reset_start(input int k);
    rst_n[k] = 0;
    @(posedge clk); #1;
    rst_n[k] = 1;
    sign = 0;
    push(halted_vec(), 1, 0, rb(), rb());
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 0; ir_i[k] = 16'hFFFF; #1;
      checks++;
      if (obv[k] !== halted_vec()) begin
        errors++;
        $display("FAIL reset_state k%0d got %h exp %h", k, obv[k], halted_vec());
      end
      @(posedge clk); #1;
      rst_n[k] = 1;
      for (int i = 0; i < 3; i++) push(halted_vec(), 0, 0, rb(), rb());
      run_q(k, "halt_idle", -1);
    end
  endtask

  task automatic test_add();
    reset_start(0);
    build(0, 16'h1261, 16'h0005, 0, 0);
    push_fmar(16'h1261);
    run_q(0, "add_seq", -1);
  endtask

  task automatic test_branch();
    reset_start(0);
    build(0, 16'h1261, 16'h0000, 0, 0);
    build(0, 16'h0405, rb(), 0, 0);
    build(0, 16'h1261, 16'h8000, 0, 0);
    build(0, 16'h0405, rb(), 0, 0);
    push_fmar(16'h0000);
    run_q(0, "branch", -1);
  endtask

  task automatic test_store_waits();
    for (int k = 0; k < 3; k++) begin
      reset_start(k);
      build(k, 16'h7442, rb(), 0, 0);
      build(k, 16'h6A85, 16'h0001, 0, 0);
      push_fmar(16'h0000);
      run_q(k, "str_ldr_wait", -1);
    end
  endtask

  task automatic test_pause();
    reset_start(0);
    build(0, 16'hD00F, rb(), 3, 2);
    build(0, 16'hD00F, rb(), 0, 0);
    push_fmar(16'h0000);
    run_q(0, "pause", -1);
  endtask

  task automatic test_reset_mid_ldr();
    reset_start(0);
    build(0, 16'h1261, 16'h8000, 0, 0);
    build(0, 16'h6A85, 16'h0001, 0, 0);
    run_q(0, "pre_abort", 14);   // halted + ADD(6) + LDR up to first LDR_RD
    checks++;
    if (obv[0].oe_n !== 1'b0) begin
      errors++;
      $display("FAIL ldr_rd_strobe got %b exp 0", obv[0].oe_n);
    end
    rst_n[0] = 0; #1;
    checks++;
    if (obv[0] !== halted_vec()) begin
      errors++;
      $display("FAIL abort_reset got %h exp %h", obv[0], halted_vec());
    end
    @(posedge clk); #1;
    rst_n[0] = 1;
    sign = 0;
    push(halted_vec(), 1, 0, rb(), rb());
    build(0, 16'h0405, rb(), 0, 0);   // taken only if Z came back on reset
    build(0, 16'hA000, rb(), 0, 0);
    push_fmar(16'h0000);
    run_q(0, "post_abort", -1);
  endtask

  task automatic test_random();
    logic [3:0]  ops [16] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h4, 4'h6, 4'h7,
                              4'hD, 4'hA, 4'h2, 4'h3, 4'h8, 4'hE, 4'hF, 4'hB};
    logic [15:0] ir, ccb;
    for (int k = 0; k < 3; k++) begin
      reset_start(k);
      for (int n = 0; n < 30; n++) begin
        ir = {ops[$urandom_range(0, 15)], 12'($urandom)};
        case ($urandom_range(0, 2))
          0:       ccb = 16'h0000;
          1:       ccb = 16'h8000 | rb();
          default: ccb = (rb() & 16'h7FFF) | 16'h0001;
        endcase
        build(k, ir, ccb, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      push_fmar(rb());
      run_q(k, "random", -1);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 0; run_i[k] = 0; cont_i[k] = 0; ir_i[k] = '0; bus_i[k] = '0;
    end
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_branch();
    test_store_waits();
    test_pause();
    test_reset_mid_ldr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_control_fsm.md
LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, memory access wait cycles (1..7) before data is valid or a write completes.
REQ-002 SHALL have Clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have Run, Continue  input  1 each  start from Halted; resume from Pause.
REQ-005 SHALL have IR, Bus  input  16 each  instruction register value; datapath bus (CC source).
REQ-006 SHALL have GateMARMUX, GateMDR, GateALU, GatePC  output  1 each  bus drivers, one-hot or zero.
REQ-007 SHALL have LD_REG, LD_BEN, LD_CC, LD_IR, LD_MAR, LD_MDR, LD_PC, LD_LED  output  1 each  register loads.
REQ-008 SHALL have ADDR1MUX, SR2MUX, MIO_EN  output  1 each; PCMUX, DRMUX, ADDR2MUX, SR1MUX, ALUK  output  2 each  datapath selects.
REQ-009 SHALL have Mem_OE_n, Mem_WE_n  output  1 each  active-low memory strobes; Halted  output  1  in Halted state.

Function
REQ-010 SHALL be a Moore FSM; all outputs decode from current state (and IR[5] for SR2MUX) only.
REQ-011 SHALL implement states HALTED, F_MAR (MAR<-PC, PC<-PC+1), F_RD (MIO_EN=1, LD_MDR, Mem_OE_n=0), F_IR (IR<-MDR), DECODE (LD_BEN), ADD, AND, NOT, BR, BR_TAKE, JMP, JSR_R7, JSR_PC, LDR_MAR, LDR_RD, LDR_WB, STR_MAR, STR_MDR, STR_WR, PAUSE1, PAUSE2.
REQ-012 SHALL leave HALTED for F_MAR on the first cycle Run=1; otherwise stay.
REQ-013 SHALL hold F_RD, LDR_RD, STR_WR for exactly MEM_WAIT cycles via an internal down-counter, reloaded on state entry; strobes asserted every cycle of the hold.
REQ-014 SHALL decode IR[15:12] in DECODE: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR, 0111 STR, 1101 PAUSE; any other opcode SHALL return to F_MAR (NOP).
REQ-015 SHALL drive ADD/AND/NOT: SR1MUX=01, DRMUX=00, ALUK=00/01/10, GateALU, LD_REG, LD_CC; next F_MAR.
REQ-016 SHALL in BR go to BR_TAKE if BEN=1 else F_MAR; BR_TAKE: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC.
REQ-017 SHALL in JMP: SR1MUX=01, ALUK=11, GateALU, PCMUX=01, LD_PC.
REQ-018 SHALL in JSR_R7: GatePC, DRMUX=01, LD_REG; JSR_PC: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC (offset11 form only).
REQ-019 SHALL in LDR/STR _MAR: SR1MUX=01, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR; LDR_WB: GateMDR, DRMUX=00, LD_REG, LD_CC; STR_MDR: SR1MUX=00, ALUK=11, GateALU, MIO_EN=0, LD_MDR; STR_WR: Mem_WE_n=0.
REQ-020 SHALL in PAUSE1 assert LD_LED one cycle, wait for Continue=1 -> PAUSE2, wait Continue=0 -> F_MAR.
REQ-021 SHALL hold internal NZP, loaded on LD_CC edge: N=Bus[15], Z=(Bus==0), P=otherwise; exactly one bit set.
REQ-022 SHALL load BEN = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) on the DECODE edge.
REQ-023 SHALL drive SR2MUX=IR[5]; unlisted controls SHALL be 0, strobes 1.

Reset
REQ-024 SHALL on Reset=0, asynchronously: state HALTED, counter 0, NZP=010, BEN=0; all Gate/LD/select outputs 0, Mem_OE_n=Mem_WE_n=1, Halted=1.
REQ-025 SHALL abort any in-progress memory access on reset, deasserting strobes in the same cycle reset asserts.

Structure
REQ-026 SHALL place the state enum, opcode constants and ALUK/PCMUX/ADDR2MUX encodings in shared package lc3_pkg.
REQ-027 SHALL isolate NZP/BEN logic in sub-module nzp_ben_unit.

Verification
REQ-028 Reset, Run=1, IR=0x1261 (ADD R1,R1,#1) -> F_MAR,F_RD x MEM_WAIT,F_IR,DECODE,ADD; LD_REG+LD_CC in ADD; back in F_MAR after 4+MEM_WAIT cycles.
REQ-029 Bus=0x0000 on LD_CC then IR=0x0405 (BRz) -> BR_TAKE with PCMUX=10; same with Bus=0x8000 -> BR then F_MAR.
REQ-030 IR=0x7442 (STR) -> Mem_WE_n=0 exactly MEM_WAIT cycles in STR_WR, never during F_RD; MEM_WAIT=1 and 7 both pass.
REQ-031 IR=0xD00F (PAUSE) -> LD_LED one cycle; Continue pulse 1 then 0 -> F_MAR; Continue held 1 stays PAUSE2.
REQ-032 Reset=0 mid-LDR_RD -> HALTED, Mem_OE_n=1 same cycle, NZP=010; IR=0xA000 (illegal) -> DECODE then F_MAR.
